sha_buf_arbiter: RTL and testbench

Sequencer/arbiter that shares the single-port 32-byte SHA message/digest register bank between two requesters: the host (byte load/unload) and the SHA engine (block read/write). It grants whole bursts with round-robin or fixed priority, generates incrementing, wrapping byte addresses, and drives the bank's en/wr/addr/data_in pins. Bank read data is combinational, so this block registers it back to the owner.

---
 rtl/sha_buf_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_sha_buf_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_buf_arbiter.sv
// sha_buf_arbiter
// Shares the single-port 32-byte SHA message/digest bank between the host
// (byte load/unload) and the SHA engine (block read/write). Whole bursts are
// granted one at a time. Arbitration is round-robin (RR=1) or engine-first
// (RR=0). Each burst walks incrementing byte addresses that wrap at the top of
// the bank. Combinational bank read data is registered back to the burst owner.
//
// Optional feature macro: SHA_BUF_CLR_EN
//   Defined   : a clr_req pulse queues a 32-beat zero fill of the bank. The fill
//               runs at the next idle slot, ahead of both requesters.
//   Undefined : clr_req is ignored, clr_busy is tied low, and there is no
//               clear state.
module sha_buf_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_req,
  input  logic              h_wr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [ADDR_W-1:0] h_len,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic              h_done,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              e_req,
  input  logic              e_wr,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [ADDR_W-1:0] e_len,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_ack,
  output logic              e_done,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef SHA_BUF_CLR_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_CLEAR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1
  } state_t;
`endif

  state_t state_q, state_d;

  // Burst context latched at grant
  logic              own_eng_q;   // 1 = engine owns the current burst
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;       // beats remaining after the current one
  logic              last_eng_q;  // owner of the most recent grant

  // Arbitration decisions for this cycle
  logic              grant;
  logic              grant_eng;
  logic              clr_start;
  logic              clr_pend_q;
  logic              beat_p0;
  logic              rd_beat_p0;

  // Read return registers, one per requester
  logic              h_vld_p1;
  logic              e_vld_p1;
  logic [DATA_W-1:0] h_rdata_p1;
  logic [DATA_W-1:0] e_rdata_p1;

  // Next byte address; the natural ADDR_W-bit overflow gives the 31 -> 0 wrap
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

  // Tie-break: round-robin favours whoever did not win last time
  function automatic logic pick_engine(input logic hr, input logic er,
                                       input logic last_eng);
    logic sel;
    if (hr && er) begin
      sel = (RR != 0) ? ~last_eng : 1'b1;
    end else begin
      sel = er;
    end
    return sel;
  endfunction

  assign beat_p0    = (state_q != S_IDLE);
  assign rd_beat_p0 = (state_q == S_BURST) && !wr_q;
  assign clr_start  = (state_q == S_IDLE) && clr_pend_q;

`ifdef SHA_BUF_CLR_EN
  // Clear request is remembered until the next idle slot picks it up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_pend_q <= 1'b0;
    end else if (clr_start) begin
      clr_pend_q <= 1'b0;
    end else if (clr_req && (state_q != S_CLEAR)) begin
      clr_pend_q <= 1'b1;
    end
  end

  assign clr_busy = clr_pend_q | (state_q == S_CLEAR);
`else
  logic unused_clr_req;
  assign unused_clr_req = clr_req;
  assign clr_pend_q     = 1'b0;
  assign clr_busy       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and grant decision
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_eng = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef SHA_BUF_CLR_EN
        if (clr_pend_q) begin
          state_d = S_CLEAR;
        end else
`endif
        if (h_req || e_req) begin
          grant     = 1'b1;
          grant_eng = pick_engine(h_req, e_req, last_eng_q);
          state_d   = S_BURST;
        end
      end
      S_BURST: begin
        if (cnt_q == '0) state_d = S_IDLE;
      end
`ifdef SHA_BUF_CLR_EN
      S_CLEAR: begin
        if (cnt_q == '0) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Burst context: latch on grant or clear start, then step once per beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_eng_q  <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      last_eng_q <= 1'b1;
    end else if (grant) begin
      own_eng_q  <= grant_eng;
      wr_q       <= grant_eng ? e_wr   : h_wr;
      addr_q     <= grant_eng ? e_addr : h_addr;
      cnt_q      <= grant_eng ? e_len  : h_len;
      last_eng_q <= grant_eng;
    end else if (clr_start) begin
      wr_q   <= 1'b1;
      addr_q <= '0;
      cnt_q  <= '1;
    end else if (beat_p0) begin
      addr_q <= addr_inc(addr_q);
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // ---- stage p0 -> p1: register combinational bank read data to its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_vld_p1   <= 1'b0;
      e_vld_p1   <= 1'b0;
      h_rdata_p1 <= '0;
      e_rdata_p1 <= '0;
    end else begin
      h_vld_p1 <= rd_beat_p0 && !own_eng_q;
      e_vld_p1 <= rd_beat_p0 &&  own_eng_q;
      if (rd_beat_p0 && !own_eng_q) h_rdata_p1 <= mem_rdata;
      if (rd_beat_p0 &&  own_eng_q) e_rdata_p1 <= mem_rdata;
    end
  end

  assign h_rvalid = h_vld_p1;
  assign h_rdata  = h_rdata_p1;
  assign e_rvalid = e_vld_p1;
  assign e_rdata  = e_rdata_p1;

  // Bank pins and requester handshakes decoded from the current state
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    h_ack     = 1'b0;
    h_done    = 1'b0;
    e_ack     = 1'b0;
    e_done    = 1'b0;
    case (state_q)
      S_BURST: begin
        mem_en    = 1'b1;
        mem_wr    = wr_q;
        mem_addr  = addr_q;
        mem_wdata = own_eng_q ? e_wdata : h_wdata;
        h_ack     = !own_eng_q;
        e_ack     =  own_eng_q;
        h_done    = !own_eng_q && (cnt_q == '0);
        e_done    =  own_eng_q && (cnt_q == '0);
      end
`ifdef SHA_BUF_CLR_EN
      S_CLEAR: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = '0;
      end
`endif
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sha_buf_arbiter.sv
// Directed bench for sha_buf_arbiter: table of single/short bursts, then
// hand-written sequences for wrap, arbitration order, async reset, full-bank
// bursts and (when SHA_BUF_CLR_EN is defined) the clear sequence.
module tb_sha_buf_arbiter;

  logic       clk;
  logic       rst_n;
  logic       h_req, h_wr;
  logic [4:0] h_addr, h_len;
  logic [7:0] h_wdata;
  logic       h_ack, h_done, h_rvalid;
  logic [7:0] h_rdata;
  logic       e_req, e_wr;
  logic [4:0] e_addr, e_len;
  logic [7:0] e_wdata;
  logic       e_ack, e_done, e_rvalid;
  logic [7:0] e_rdata;
  logic       clr_req, clr_busy;
  logic       mem_en, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  // Second instance with fixed priority, used for the tie-break check
  logic       d0_h_ack, d0_h_done, d0_h_rvalid;
  logic       d0_e_ack, d0_e_done, d0_e_rvalid;
  logic       d0_mem_en;
  logic [7:0] d0_unused_h_rdata, d0_unused_e_rdata, d0_unused_mem_wdata;
  logic       d0_unused_clr_busy, d0_unused_mem_wr;
  logic [4:0] d0_unused_mem_addr;
  logic [7:0] d0_rdata;

  logic [7:0] bank   [32];
  logic [7:0] shadow [32];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       eng;
    logic       wr;
    logic [4:0] addr;
    logic [4:0] len;
    logic [7:0] seed;
    logic [7:0] exp;   // written byte at addr, or last byte read back
  } vec_t;

  vec_t vecs [8];

  sha_buf_arbiter #(.ADDR_W(5), .DATA_W(8), .RR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_len(h_len), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_done(h_done), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .e_req(e_req), .e_wr(e_wr), .e_addr(e_addr), .e_len(e_len), .e_wdata(e_wdata),
    .e_ack(e_ack), .e_done(e_done), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  sha_buf_arbiter #(.ADDR_W(5), .DATA_W(8), .RR(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_len(h_len), .h_wdata(h_wdata),
    .h_ack(d0_h_ack), .h_done(d0_h_done), .h_rvalid(d0_h_rvalid), .h_rdata(d0_unused_h_rdata),
    .e_req(e_req), .e_wr(e_wr), .e_addr(e_addr), .e_len(e_len), .e_wdata(e_wdata),
    .e_ack(d0_e_ack), .e_done(d0_e_done), .e_rvalid(d0_e_rvalid), .e_rdata(d0_unused_e_rdata),
    .clr_req(clr_req), .clr_busy(d0_unused_clr_busy),
    .mem_en(d0_mem_en), .mem_wr(d0_unused_mem_wr), .mem_addr(d0_unused_mem_addr),
    .mem_wdata(d0_unused_mem_wdata), .mem_rdata(d0_rdata)
  );

  assign d0_rdata = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port bank: synchronous write, combinational read
  always @(posedge clk) if (mem_en && mem_wr) bank[mem_addr] <= mem_wdata;
  assign mem_rdata = bank[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dat(input logic [7:0] seed, input int i);
    return 8'(int'(seed) * (i + 1));
  endfunction

  task automatic drive(input logic eng, input logic req, input logic wr,
                       input logic [4:0] addr, input logic [4:0] len, input logic [7:0] wd);
    if (eng) begin
      e_req = req; e_wr = wr; e_addr = addr; e_len = len; e_wdata = wd;
    end else begin
      h_req = req; h_wr = wr; h_addr = addr; h_len = len; h_wdata = wd;
    end
  endtask

  // One complete burst from a single requester, called at the start of an idle cycle
  task automatic burst(input logic eng, input logic wr, input logic [4:0] addr,
                       input logic [4:0] len, input logic [7:0] seed, input string tag);
    logic [4:0] a;
    logic [4:0] prev;
    prev = addr;
    drive(eng, 1'b1, wr, addr, len, seed);
    @(negedge clk);
    chk($sformatf("%s_arb_en", tag), mem_en, 1'b0);
    tick();
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 5'(i);
      @(negedge clk);
      chk($sformatf("%s_en%0d", tag, i), mem_en, 1'b1);
      chk($sformatf("%s_wr%0d", tag, i), mem_wr, wr);
      chk($sformatf("%s_addr%0d", tag, i), mem_addr, a);
      chk($sformatf("%s_ack%0d", tag, i), eng ? e_ack : h_ack, 1'b1);
      chk($sformatf("%s_oack%0d", tag, i), eng ? h_ack : e_ack, 1'b0);
      chk($sformatf("%s_done%0d", tag, i), eng ? e_done : h_done, (i == int'(len)));
      chk($sformatf("%s_rv%0d", tag, i), eng ? e_rvalid : h_rvalid, (!wr && i > 0));
      if (wr) chk($sformatf("%s_wd%0d", tag, i), mem_wdata, dat(seed, i));
      if (!wr && i > 0) chk($sformatf("%s_rd%0d", tag, i), eng ? e_rdata : h_rdata, shadow[prev]);
      tick();
      if (wr) shadow[a] = dat(seed, i);
      if (i < int'(len)) begin
        if (eng) e_wdata = dat(seed, i + 1); else h_wdata = dat(seed, i + 1);
      end else begin
        if (eng) e_req = 1'b0; else h_req = 1'b0;
      end
      prev = a;
    end
    @(negedge clk);
    chk($sformatf("%s_gap_en", tag), mem_en, 1'b0);
    chk($sformatf("%s_tail_rv", tag), eng ? e_rvalid : h_rvalid, !wr);
    chk($sformatf("%s_tail_orv", tag), eng ? h_rvalid : e_rvalid, 1'b0);
    if (!wr) chk($sformatf("%s_tail_rd", tag), eng ? e_rdata : h_rdata, shadow[prev]);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int hacks, cb;
    logic hd, ed, e_seen;

    //             eng   wr    addr   len   seed   exp
    vecs[0] = '{1'b0, 1'b1, 5'd3,  5'd0, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 5'd7,  5'd0, 8'h5A, 8'h5A};
    vecs[2] = '{1'b0, 1'b0, 5'd7,  5'd0, 8'h00, 8'h5A};
    vecs[3] = '{1'b1, 1'b0, 5'd3,  5'd0, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 1'b1, 5'd31, 5'd0, 8'hFF, 8'hFF};
    vecs[5] = '{1'b0, 1'b0, 5'd31, 5'd0, 8'h00, 8'hFF};
    vecs[6] = '{1'b0, 1'b1, 5'd0,  5'd1, 8'h3C, 8'h3C};
    vecs[7] = '{1'b1, 1'b0, 5'd0,  5'd1, 8'h00, 8'h78};

    rst_n = 1'b0; clr_req = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 5'd0);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_acks", {h_ack, e_ack, h_done, e_done}, 4'b0000);
    chk("rst_rvalid", {h_rvalid, e_rvalid}, 2'b00);
    chk("rst_h_rdata", h_rdata, 8'h00);
    chk("rst_e_rdata", e_rdata, 8'h00);
    chk("rst_clr_busy", clr_busy, 1'b0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_en", mem_en, 1'b0);
    tick();

    // Table of short bursts
    for (int v = 0; v < 8; v++) begin
      burst(vecs[v].eng, vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].seed, $sformatf("vec%0d", v));
      if (vecs[v].wr) chk($sformatf("vec%0d_bank", v), bank[vecs[v].addr], vecs[v].exp);
      else chk($sformatf("vec%0d_hold_rd", v), vecs[v].eng ? e_rdata : h_rdata, vecs[v].exp);
    end

    // Engine read across the 31 -> 0 wrap
    burst(1'b0, 1'b1, 5'd30, 5'd3, 8'h11, "preload");
    burst(1'b1, 1'b0, 5'd30, 5'd3, 8'h00, "e_wrap");
    chk("e_wrap_last", e_rdata, 8'h44);
    chk("e_wrap_bank1", bank[1], 8'h44);

    // Arbitration order with both requesters held after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 8'h00);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("rr_h_ack%0d", c), h_ack, (c % 4 == 1));
      chk($sformatf("rr_e_ack%0d", c), e_ack, (c % 4 == 3));
      chk($sformatf("rr_en%0d", c), mem_en, (c % 2 == 1));
      chk($sformatf("fp_e_ack%0d", c), d0_e_ack, (c % 2 == 1));
      chk($sformatf("fp_h_ack%0d", c), {d0_h_ack, d0_h_done, d0_h_rvalid}, 3'b000);
      chk($sformatf("fp_en%0d", c), d0_mem_en, (c % 2 == 1));
      chk($sformatf("fp_done%0d", c), d0_e_done, (c % 2 == 1));
      chk($sformatf("fp_rv%0d", c), d0_e_rvalid, (c % 2 == 0) && c > 0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00);
    repeat (2) tick();

    // Async reset during the second beat of an 8-beat host write
    burst(1'b1, 1'b1, 5'd8, 5'd1, 8'h10, "pre89");
    drive(1'b0, 1'b1, 1'b1, 5'd8, 5'd7, 8'hC1);
    tick();
    @(negedge clk);
    chk("mr_beat0_ack", h_ack, 1'b1);
    chk("mr_beat0_addr", mem_addr, 5'd8);
    tick();
    h_wdata = 8'h82;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_en", mem_en, 1'b0);
    chk("mr_async_ack", {h_ack, h_done}, 2'b00);
    chk("mr_async_wr", mem_wr, 1'b0);
    chk("mr_async_addr", mem_addr, 5'd0);
    chk("mr_async_wdata", mem_wdata, 8'h00);
    h_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("mr_after_ack", h_ack, 1'b0);
    chk("mr_after_en", mem_en, 1'b0);
    chk("mr_bank8", bank[8], 8'hC1);
    chk("mr_bank9", bank[9], 8'h20);
    shadow[8] = 8'hC1;
    tick();

    // Full-bank host write starting mid-bank
    burst(1'b0, 1'b1, 5'd16, 5'd31, 8'h01, "full");
    bad = 0;
    for (int a = 0; a < 32; a++) if (bank[a] !== 8'(((a - 16) & 31) + 1)) bad++;
    chk("full_bank_bad_bytes", bad, 0);
    chk("full_bank15", bank[15], 8'h20);
    chk("full_bank16", bank[16], 8'h01);

`ifdef SHA_BUF_CLR_EN
    // Clear requested mid-burst; engine waits behind the clear
    hacks = 0; cb = 0; e_seen = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 5'd4, 5'd3, 8'h01);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      hd = h_done; ed = e_done;
      if (h_ack) hacks++;
      if (clr_busy && mem_en && !h_ack && !e_ack) begin
        chk($sformatf("clr_addr%0d", cb), mem_addr, 5'(cb));
        chk($sformatf("clr_wd%0d", cb), {mem_wr, mem_wdata}, 9'h100);
        cb++;
      end
      if (c == 3) chk("clr_busy_pend", clr_busy, 1'b1);
      if (c == 38) chk("clr_busy_fell", clr_busy, 1'b0);
      if (c == 39) chk("clr_e_grant", e_ack, 1'b1);
      if (e_ack) begin
        e_seen = 1'b1;
        chk("clr_e_held", clr_busy, 1'b0);
        chk("clr_e_after_fill", cb, 32);
      end
      tick();
      if (h_req) h_wdata = h_wdata + 8'h01;
      if (hd) h_req = 1'b0;
      if (ed) e_req = 1'b0;
      if (c == 1) begin
        clr_req = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 8'h00);
      end
      if (c == 2) clr_req = 1'b0;
    end
    chk("clr_host_beats", hacks, 4);
    chk("clr_beats", cb, 32);
    chk("clr_e_seen", e_seen, 1'b1);
    bad = 0;
    for (int a = 0; a < 32; a++) if (bank[a] !== 8'h00) bad++;
    chk("clr_bank_nonzero", bad, 0);
`else
    // Without the clear feature a clr_req pulse changes nothing
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("noclr_busy%0d", c), clr_busy, 1'b0);
      chk($sformatf("noclr_en%0d", c), mem_en, 1'b0);
      tick();
    end
    chk("noclr_bank16", bank[16], 8'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
